// File: rtl/logic_gate_pkg.sv
// Shared definitions for the pipelined bitwise logic lane.
// Holds the op select width and the op encodings.
package logic_gate_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_comb.sv
// Combinational multi-op gate: (a_i, b_i, op_i) -> y_o over WIDTH bits.
// Ports: a_i, b_i operands; op_i select; y_o result.
module logic_gate_comb
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_NOT:  y_o = ~a_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      OP_PASS: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// Two-stage valid/ready bitwise logic lane with result flags and
// a completed-transfer counter.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_op upstream;
// out_valid/out_ready/out_y/out_op/out_zero/out_parity downstream;
// xfer_cnt counts output handshakes.
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OP_W-1:0]  out_op,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OP_W-1:0]  op1_q, op1_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [OP_W-1:0]  op2_q, op2_d;
  logic             zero_q, zero_d;
  logic             par_q, par_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv;
  logic [WIDTH-1:0] y_c;

  logic_gate_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op1_q),
    .y_o  (y_c)
  );

  // Stage 2 can take a beat if empty or draining this cycle.
  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op1_d      = op1_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    op2_d      = op2_q;
    zero_d     = zero_q;
    par_d      = par_q;
    cnt_d      = cnt_q;

    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      a_d   = in_a;
      b_d   = in_b;
      op1_d = in_op;
    end

    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv && s1_valid_q) begin
      y_d    = y_c;
      op2_d  = op1_q;
      zero_d = (y_c == '0);
      par_d  = ^y_c;
    end

    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op1_q      <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      op2_q      <= '0;
      zero_q     <= 1'b0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op1_q      <= op1_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      op2_q      <= op2_d;
      zero_q     <= zero_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_y      = y_q;
  assign out_op     = op2_q;
  assign out_zero   = zero_q;
  assign out_parity = par_q;
  assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Self-checking bench for logic_gate_pipe: vector table, corner
// sequences, and a randomized run against a truth-table model.
module tb_logic_gate_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_y;
  logic [2:0] out_op;
  logic       out_zero;
  logic       out_parity;
  logic [15:0] xfer_cnt;

  logic       in_ready4, out_valid4, out_zero4, out_parity4;
  logic [7:0] out_y4;
  logic [2:0] out_op4;
  logic [3:0] xfer_cnt4;

  always #5 clk = ~clk;

  logic_gate_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op),
    .out_zero(out_zero), .out_parity(out_parity),
    .xfer_cnt(xfer_cnt)
  );

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_y(out_y4), .out_op(out_op4),
    .out_zero(out_zero4), .out_parity(out_parity4),
    .xfer_cnt(xfer_cnt4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
    logic       p;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
  } exp_t;

  int total = 0;
  int bad = 0;
  int cnt = 0;
  int cyc = 0;
  exp_t q[$];
  logic [7:0] em_y[$];
  int em_cyc[$];
  vec_t tbl[13];
  logic [3:0] tt[8];

  logic       hold_pend = 1'b0;
  logic [7:0] h_y;
  logic [2:0] h_op;
  logic       h_z, h_p;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: each op is a 2-input truth table applied per bit.
  function automatic logic [7:0] ref_y(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [2:0] op);
    logic [7:0] r;
    logic [3:0] t;
    t = tt[op];
    for (int i = 0; i < 8; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic step(input logic v, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] op,
                      input logic r);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = r;
    #1;
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_y", out_y, h_y);
      chk("hold_op", out_op, h_op);
      chk("hold_flags", {out_zero, out_parity}, {h_z, h_p});
    end
    hold_pend = out_valid && !out_ready;
    h_y = out_y; h_op = out_op; h_z = out_zero; h_p = out_parity;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_y", out_y, e.y);
        chk("sb_op", out_op, e.op);
        chk("sb_zero", out_zero, e.y == 8'h00);
        chk("sb_par", out_parity, $countones(e.y) % 2);
      end
      cnt++;
      em_y.push_back(out_y);
      em_cyc.push_back(cyc);
    end
    if (in_valid && in_ready) begin
      e.y = ref_y(a, b, op);
      e.op = op;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 8'h00, 3'd0, 1);
  endtask

  initial begin
    int acc;
    tt[0] = 4'b0011; tt[1] = 4'b1000; tt[2] = 4'b1110;
    tt[3] = 4'b0110; tt[4] = 4'b0111; tt[5] = 4'b0001;
    tt[6] = 4'b1001; tt[7] = 4'b1100;

    tbl[0]  = '{8'hA5, 8'h00, 3'd0, 8'h5A, 1'b0, 1'b0};
    tbl[1]  = '{8'hF0, 8'hCC, 3'd1, 8'hC0, 1'b0, 1'b0};
    tbl[2]  = '{8'hF0, 8'hCC, 3'd2, 8'hFC, 1'b0, 1'b0};
    tbl[3]  = '{8'hF0, 8'hCC, 3'd3, 8'h3C, 1'b0, 1'b0};
    tbl[4]  = '{8'hF0, 8'hCC, 3'd4, 8'h3F, 1'b0, 1'b0};
    tbl[5]  = '{8'hF0, 8'hCC, 3'd5, 8'h03, 1'b0, 1'b0};
    tbl[6]  = '{8'hF0, 8'hCC, 3'd6, 8'hC3, 1'b0, 1'b0};
    tbl[7]  = '{8'hF0, 8'hCC, 3'd7, 8'hF0, 1'b0, 1'b0};
    tbl[8]  = '{8'hF0, 8'hCC, 3'd0, 8'h0F, 1'b0, 1'b0};
    tbl[9]  = '{8'h0F, 8'hF0, 3'd1, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{8'h01, 8'h00, 3'd3, 8'h01, 1'b0, 1'b1};
    tbl[11] = '{8'h07, 8'h5A, 3'd7, 8'h07, 1'b0, 1'b1};
    tbl[12] = '{8'hFF, 8'hFF, 3'd4, 8'h00, 1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_y", out_y, 0);
    chk("rst_flags", {out_op, out_zero, out_parity}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ops 1..7 then 0 back-to-back
    em_y.delete(); em_cyc.delete();
    for (int i = 1; i <= 8; i++)
      step(1, tbl[i].a, tbl[i].b, tbl[i].op, 1);
    idle(3);
    chk("b2b_count", em_y.size(), 8);
    for (int k = 0; k < em_y.size() && k < 8; k++) begin
      chk("b2b_y", em_y[k], tbl[k+1].y);
      chk("b2b_cyc", em_cyc[k], em_cyc[0] + k);
    end
    chk("b2b_xfer", xfer_cnt, 8);
    chk("b2b_xfer4", xfer_cnt4, 8);

    // Table: single beats with exact 2-clock latency
    for (int i = 0; i < 13; i++) begin
      step(1, tbl[i].a, tbl[i].b, tbl[i].op, 1);
      chk("lat_early", out_valid, 0);
      step(0, 8'h00, 8'h00, 3'd0, 1);
      chk("lat_valid", out_valid, 1);
      chk("tbl_y", out_y, tbl[i].y);
      chk("tbl_op", out_op, tbl[i].op);
      chk("tbl_zero", out_zero, tbl[i].z);
      chk("tbl_par", out_parity, tbl[i].p);
      step(0, 8'h00, 8'h00, 3'd0, 1);
    end
    idle(2);
    chk("tbl_xfer", xfer_cnt, cnt);

    // Backpressure: 5 cycles stalled with in_valid high
    for (int i = 0; i < 5; i++)
      step(1, 8'h40 + 8'(i), 8'h0F, 3'(i), 0);
    acc = q.size();
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    idle(4);
    chk("bp_drained", q.size(), 0);
    chk("bp_idle", out_valid, 0);
    chk("bp_xfer", xfer_cnt, cnt);

    // Full pipe: accept and emit in the same cycle, no bubble
    step(1, 8'h11, 8'h22, 3'd2, 0);
    step(1, 8'h33, 8'h44, 3'd3, 0);
    em_y.delete(); em_cyc.delete();
    for (int i = 0; i < 4; i++)
      step(1, 8'h50 + 8'(i), 8'hA0, 3'(i + 4), 1);
    idle(3);
    chk("full_count", em_y.size(), 6);
    chk("full_nobubble", em_cyc[em_cyc.size()-1] - em_cyc[0], 5);
    chk("full_drained", q.size(), 0);

    // Reset mid-stream with 2 beats in flight
    step(1, 8'h12, 8'h34, 3'd3, 0);
    step(1, 8'h56, 8'h78, 3'd1, 0);
    chk("pre_rst_xfer_nz", xfer_cnt != 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_xfer", xfer_cnt, 0);
    in_valid = 1'b0;
    q.delete();
    cnt = 0;
    hold_pend = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    em_y.delete();
    idle(4);
    chk("no_stale_beat", em_y.size(), 0);
    chk("post_rst_xfer", xfer_cnt, 0);

    // Counter wrap: 17 transfers
    for (int i = 0; i < 17; i++)
      step(1, 8'(i * 7), 8'(i * 3), 3'(i), 1);
    idle(3);
    chk("wrap_xfer4", xfer_cnt4, 1);
    chk("wrap_xfer16", xfer_cnt, 17);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           3'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 6; i++) step(0, 8'h00, 8'h00, 3'd0, 1);
    chk("rand_drained", q.size(), 0);
    chk("rand_xfer16", xfer_cnt, cnt % 65536);
    chk("rand_xfer4", xfer_cnt4, cnt % 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
